fifo_uart_tx: RTL

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/uart_tx_pkg.sv | 34 +++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/fifo_uart_tx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared constants and one-hot state encoding for fifo_uart_tx
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BITS_PER_BYTE  = 8;
  localparam int STOP_BITS      = 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [6:0] {
    S_IDLE   = 7'b000_0001,
    S_FETCH  = 7'b000_0010,
    S_LOAD   = 7'b000_0100,
    S_START  = 7'b000_1000,
    S_DATA   = 7'b001_0000,
    S_PARITY = 7'b010_0000,
    S_STOP   = 7'b100_0000
  } state_t;

  function automatic logic even_parity(input logic [BITS_PER_BYTE-1:0] b);
    return ^b;
  endfunction
`else
  typedef enum logic [5:0] {
    S_IDLE  = 6'b00_0001,
    S_FETCH = 6'b00_0010,
    S_LOAD  = 6'b00_0100,
    S_START = 6'b00_1000,
    S_DATA  = 6'b01_0000,
    S_STOP  = 6'b10_0000
  } state_t;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit timer counting 0..CLK_DIV-1 with sync clear
// tick marks the last cycle of a bit; the counter wraps on it so bits never drift.
module uart_baud_tick #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = !clear && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops 32-bit words from a FIFO and sends them as 4 UART bytes, LSB byte first
// Optional even parity bit per byte with UART_TX_PARITY_EN.
module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] rd_data,
  output logic             rd_en,
  output logic             txd,
  output logic             busy,
  output logic             word_done
);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [1:0]       byte_cnt;
  logic [2:0]       bit_cnt;
  logic             tick;
  logic             timer_clear;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  // Timer is held at zero until the start bit so every frame begins on a fresh bit period.
  assign timer_clear = (state == S_IDLE) || (state == S_FETCH) || (state == S_LOAD);
  assign busy        = (state != S_IDLE);

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      txd        <= 1'b1;
      rd_en      <= 1'b0;
      word_done  <= 1'b0;
      shreg      <= '0;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      rd_en     <= 1'b0;
      word_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          txd <= 1'b1;
          if (!fifo_empty) begin
            state <= S_FETCH;
            rd_en <= 1'b1;
          end
        end
        S_FETCH: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          shreg    <= rd_data;
          byte_cnt <= '0;
          bit_cnt  <= '0;
          state    <= S_START;
          txd      <= 1'b0;
        end
        S_START: begin
          if (tick) begin
            state   <= S_DATA;
            txd     <= shreg[0];
            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= even_parity(shreg[BITS_PER_BYTE-1:0]);
`endif
          end
        end
        S_DATA: begin
          if (tick) begin
            // Shifting one bit per data bit leaves the next byte in the low lane after 8 bits.
            shreg <= shreg >> 1;
            if (bit_cnt == 3'(BITS_PER_BYTE - 1)) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= S_PARITY;
              txd     <= parity_bit;
`else
              state   <= S_STOP;
              txd     <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              txd     <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            state <= S_STOP;
            txd   <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (bit_cnt != 3'(STOP_BITS - 1)) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
              state     <= S_IDLE;
              word_done <= 1'b1;
              bit_cnt   <= '0;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
              bit_cnt  <= '0;
              state    <= S_START;
              txd      <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule
